// File: rtl/arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: RAM handshake
// status and arbiter FSM state.
package arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of pipeline-side request/response and RAM-side handshake signals
// around the memory arbiter; master is the arbiter's view.
interface memory_arbiter_if;
    import arbiter_pkg::*;

    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    ramstate_t   ramstate;
    logic [31:0] ramload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        mem_fault;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload,
               mem_fault
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload,
               mem_fault
    );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data memory:
// one latched access at a time, data priority, bounded fetch starvation.
module memory_arbiter
    import arbiter_pkg::*;
#(
    parameter int TIMEOUT      = 64,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    memory_arbiter_if.master  bus
);

    localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state_q,   state_d;
    logic [STREAK_W-1:0] dstreak_q, dstreak_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic [31:0]         addr_q,    addr_d;
    logic [31:0]         store_q,   store_d;
    logic                wen_q,     wen_d;

    logic        d_req;
    logic        i_wins;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            store_q   <= '0;
            wen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            wen_q     <= wen_d;
        end
    end

    assign d_req  = bus.dREN | bus.dWEN;
    // A waiting fetch only overrides data once the streak has saturated.
    assign i_wins = bus.iREN & (~d_req | (dstreak_q == STREAK_MAX));

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wen_d     = wen_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = '0;
        dload     = '0;

        unique case (state_q)
            IDLE: begin
                if (i_wins) begin
                    state_d   = ISERV;
                    addr_d    = bus.iaddr;
                    store_d   = '0;
                    wen_d     = 1'b0;
                    dstreak_d = '0;
                    wait_d    = '0;
                end else if (d_req) begin
                    state_d   = DSERV;
                    addr_d    = bus.daddr;
                    store_d   = bus.dstore;
                    wen_d     = bus.dWEN;
                    wait_d    = '0;
                    if (!bus.iREN)
                        dstreak_d = '0;
                    else if (dstreak_q != STREAK_MAX)
                        dstreak_d = dstreak_q + STREAK_W'(1);
                end
            end

            ISERV: begin
                ram_ren   = 1'b1;
                ram_addr  = addr_q;
                ram_store = store_q;
                // A flushed fetch is dropped even if the RAM answers this cycle.
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    ihit    = 1'b1;
                    iload   = bus.ramload;
                    state_d = IDLE;
                end else if (bus.ramstate == ERROR || wait_q == WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            DSERV: begin
                ram_ren   = ~wen_q;
                ram_wen   = wen_q;
                ram_addr  = addr_q;
                ram_store = store_q;
                if (bus.ramstate == ACCESS) begin
                    dhit    = 1'b1;
                    dload   = bus.ramload;
                    state_d = IDLE;
                end else if (bus.ramstate == ERROR || wait_q == WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign bus.ramREN    = ram_ren;
    assign bus.ramWEN    = ram_wen;
    assign bus.ramaddr   = ram_addr;
    assign bus.ramstore  = ram_store;
    assign bus.ihit      = ihit;
    assign bus.dhit      = dhit;
    assign bus.iload     = iload;
    assign bus.dload     = dload;
    assign bus.mem_fault = (state_q == FAULT);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_memory_arbiter;
    import arbiter_pkg::*;

    localparam int TO   = 64;
    localparam int MAXS = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    memory_arbiter_if bus();

    memory_arbiter #(.TIMEOUT(TO), .MAX_D_STREAK(MAXS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, how long it has been served, and
    // how many data grants in a row have jumped a waiting fetch.
    int          m_owner;   // 0 nobody, 1 fetch, 2 data
    int          m_age;
    int          m_streak;
    bit          m_fault;
    bit          m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    bit          seen_ihit, seen_dhit;
    int          n_ihit, n_dhit;

    initial begin
        m_owner = 0; m_age = 0; m_streak = 0; m_fault = 0; m_wr = 0;
        m_addr = '0; m_data = '0; seen_ihit = 0; seen_dhit = 0;
        n_ihit = 0; n_dhit = 0;
        forever begin
            @(negedge CLK or negedge nRST);
            if (!nRST) begin
                m_owner = 0; m_age = 0; m_streak = 0; m_fault = 0;
                m_wr = 0; m_addr = '0; m_data = '0;
                seen_ihit = 0; seen_dhit = 0;
            end else begin
                bit in_i, in_d, e_ih, e_dh, acc;
                in_i = !m_fault && m_owner == 1;
                in_d = !m_fault && m_owner == 2;
                acc  = (bus.ramstate == ACCESS);
                e_ih = in_i && bus.iREN && acc;
                e_dh = in_d && acc;
                chk("m_ramREN",  bus.ramREN,  32'(in_i || (in_d && !m_wr)));
                chk("m_ramWEN",  bus.ramWEN,  32'(in_d && m_wr));
                chk("m_ramaddr", bus.ramaddr, (in_i || in_d) ? m_addr : 32'h0);
                chk("m_ramstore", bus.ramstore, (in_i || in_d) ? m_data : 32'h0);
                chk("m_ihit",    bus.ihit,    32'(e_ih));
                chk("m_dhit",    bus.dhit,    32'(e_dh));
                chk("m_iload",   bus.iload,   e_ih ? bus.ramload : 32'h0);
                chk("m_dload",   bus.dload,   e_dh ? bus.ramload : 32'h0);
                chk("m_fault",   bus.mem_fault, 32'(m_fault));
                seen_ihit = bus.ihit;
                seen_dhit = bus.dhit;
                if (e_ih) n_ihit++;
                if (e_dh) n_dhit++;

                if (m_fault) begin
                    // only reset leaves the fault
                end else if (m_owner == 0) begin
                    if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak == MAXS)) begin
                        m_owner  = 2;
                        m_addr   = bus.daddr;
                        m_data   = bus.dstore;
                        m_wr     = bus.dWEN;
                        m_streak = bus.iREN ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                        m_age    = 0;
                    end else if (bus.iREN) begin
                        m_owner  = 1;
                        m_addr   = bus.iaddr;
                        m_data   = 32'h0;
                        m_wr     = 0;
                        m_streak = 0;
                        m_age    = 0;
                    end
                end else if (m_owner == 1 && !bus.iREN) begin
                    m_owner = 0;
                end else if (acc) begin
                    m_owner = 0;
                end else if (bus.ramstate == ERROR || m_age + 1 == TO) begin
                    m_fault = 1;
                    m_owner = 0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
    endtask

    // Holds reset with live-looking inputs, checks every output is 0, then releases.
    task automatic do_reset();
        nRST = 0;
        bus.iREN = 1; bus.iaddr = 32'hAAAA_0000; bus.dREN = 1; bus.dWEN = 1;
        bus.daddr = 32'hBBBB_0000; bus.dstore = 32'hCCCC_0000;
        bus.ramstate = ACCESS; bus.ramload = 32'hFFFF_FFFF;
        #1;
        chk("rst_ramREN",   bus.ramREN,    0);
        chk("rst_ramWEN",   bus.ramWEN,    0);
        chk("rst_ramaddr",  bus.ramaddr,   0);
        chk("rst_ramstore", bus.ramstore,  0);
        chk("rst_ihit",     bus.ihit,      0);
        chk("rst_dhit",     bus.dhit,      0);
        chk("rst_iload",    bus.iload,     0);
        chk("rst_dload",    bus.dload,     0);
        chk("rst_fault",    bus.mem_fault, 0);
        clear_inputs();
        step();
        step();
        nRST = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seq[6];
        int exp_seq[6];
        int nh;
        int cnt;
        exp_seq = '{1, 1, 1, 1, 2, 1};
        clear_inputs();
        step();

        // Isolated fetch, RAM answers two cycles after the strobe.
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h100;
        step(); bus.ramstate = BUSY;
        sample();
        chk("if_ren_c1", bus.ramREN, 1);
        chk("if_addr_c1", bus.ramaddr, 32'h100);
        chk("if_ihit_c1", bus.ihit, 0);
        step(); sample();
        chk("if_ihit_c2", bus.ihit, 0);
        step(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        sample();
        chk("if_ihit_c3", bus.ihit, 1);
        chk("if_iload_c3", bus.iload, 32'hDEADBEEF);
        step(); bus.iREN = 0; bus.ramstate = FREE;
        sample();
        chk("if_idle_ren", bus.ramREN, 0);

        // Data write beats a simultaneous fetch; read+write counts as write.
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h140;
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h55;
        bus.ramstate = ACCESS;
        step(); sample();
        chk("wp_wen", bus.ramWEN, 1);
        chk("wp_ren", bus.ramREN, 0);
        chk("wp_store", bus.ramstore, 32'h55);
        chk("wp_addr", bus.ramaddr, 32'h200);
        chk("wp_dhit", bus.dhit, 1);
        chk("wp_ihit", bus.ihit, 0);
        step(); bus.dREN = 0; bus.dWEN = 0;
        sample();
        chk("wp_bubble", bus.ramREN, 0);
        step(); sample();
        chk("wp_ihit2", bus.ihit, 1);
        chk("wp_iaddr2", bus.ramaddr, 32'h140);
        step(); bus.iREN = 0;

        // Starvation bound: continuous data reads alongside a fetch.
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h180; bus.dREN = 1; bus.daddr = 32'h280;
        bus.ramstate = ACCESS;
        nh = 0;
        for (int c = 0; c < 60 && nh < 6; c++) begin
            sample();
            if (bus.dhit) begin seq[nh] = 1; nh++; end
            else if (bus.ihit) begin seq[nh] = 2; nh++; end
            step();
        end
        chk("sv_count", nh, 6);
        for (int k = 0; k < 6; k++)
            if (k < nh) chk($sformatf("sv_seq%0d", k), seq[k], exp_seq[k]);
        clear_inputs();

        // Fetch flushed while the RAM is busy.
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h1C0; bus.ramstate = BUSY;
        step(); sample();
        chk("ab_ren_c1", bus.ramREN, 1);
        step(); bus.iREN = 0;
        sample();
        chk("ab_ihit_c2", bus.ihit, 0);
        step(); sample();
        chk("ab_ren_c3", bus.ramREN, 0);
        chk("ab_addr_c3", bus.ramaddr, 0);
        chk("ab_ihit_c3", bus.ihit, 0);

        // RAM error: sticky fault until reset.
        do_reset();
        bus.dREN = 1; bus.daddr = 32'h240; bus.ramstate = BUSY;
        step(); bus.ramstate = ERROR;
        sample();
        chk("er_dhit", bus.dhit, 0);
        step(); bus.ramstate = ACCESS; bus.dREN = 0;
        sample();
        chk("er_fault", bus.mem_fault, 1);
        chk("er_ren", bus.ramREN, 0);
        repeat (5) step();
        bus.dREN = 1; bus.iREN = 1;
        sample();
        chk("er_hold", bus.mem_fault, 1);
        chk("er_nohit", bus.dhit | bus.ihit, 0);
        step();

        // Timeout: RAM never answers; strobes last TO cycles, then fault.
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h300; bus.ramstate = BUSY;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            step(); sample();
            if (bus.ramREN) cnt++;
            if (bus.mem_fault) break;
        end
        chk("to_cycles", cnt, TO);
        chk("to_fault", bus.mem_fault, 1);

        // Async reset in the middle of a data access.
        do_reset();
        bus.dREN = 1; bus.daddr = 32'h3C0; bus.ramstate = BUSY;
        step(); sample();
        chk("ar_ren_c1", bus.ramREN, 1);
        step();
        bus.ramstate = ACCESS; nRST = 0;
        #1;
        chk("ar_ren", bus.ramREN, 0);
        chk("ar_dhit", bus.dhit, 0);
        chk("ar_addr", bus.ramaddr, 0);
        chk("ar_dload", bus.dload, 0);
        step();
        nRST = 1; bus.ramload = 32'h12345678;
        step(); sample();
        chk("ar_dhit_after", bus.dhit, 1);
        chk("ar_dload_after", bus.dload, 32'h12345678);
        chk("ar_addr_after", bus.ramaddr, 32'h3C0);
        step(); clear_inputs();

        // Randomized traffic against the model.
        do_reset();
        n_ihit = 0; n_dhit = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            step();
            if (seen_ihit) bus.iREN = 0;
            else if (bus.iREN && $urandom_range(0, 49) == 0) bus.iREN = 0;
            else if (!bus.iREN && $urandom_range(0, 2) == 0) begin
                bus.iREN = 1; bus.iaddr = $urandom;
            end
            if (seen_dhit) begin
                bus.dREN = 0; bus.dWEN = 0;
            end else if ((bus.dREN || bus.dWEN) && $urandom_range(0, 79) == 0) begin
                bus.dREN = 0; bus.dWEN = 0;
            end else if (!(bus.dREN || bus.dWEN) && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 2);
                bus.dREN = (r != 1); bus.dWEN = (r != 0);
                bus.daddr = $urandom; bus.dstore = $urandom;
            end
            r = $urandom_range(0, 9);
            if (r < 4) bus.ramstate = ACCESS;
            else if (r < 9) bus.ramstate = BUSY;
            else bus.ramstate = FREE;
            bus.ramload = $urandom;
        end
        sample();
        chk("rnd_ihits", 32'(n_ihit > 50), 1);
        chk("rnd_dhits", 32'(n_dhit > 50), 1);
        chk("rnd_nofault", bus.mem_fault, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
